// File: rtl/jump_redirect_unit_pkg.sv
// Shared definitions for the jump redirect path: PC width, FSM encodings,
// default source count and the named jump-target source indices.
package jump_redirect_unit_pkg;

  localparam int JR_PC_W          = 16;
  localparam int JR_NUM_SRC_DEF   = 3;
  localparam int JR_SRC_IDX_W_DEF = 3;

  localparam logic [2:0] JR_SRC_ALU  = 3'd0;
  localparam logic [2:0] JR_SRC_JANS = 3'd1;
  localparam logic [2:0] JR_SRC_EXC  = 3'd2;

  typedef enum logic {
    JR_STATE_IDLE = 1'b0,
    JR_STATE_PEND = 1'b1
  } jr_state_t;

  // Lower index means higher priority.
  function automatic logic jr_outranks(input logic [7:0] cand, input logic [7:0] held);
    return (cand < held);
  endfunction

endpackage

// File: rtl/jump_redirect_unit_prio_enc.sv
// Fixed-priority encoder over jump-target request strobes; index 0 wins.
module jump_src_prio_enc
  import jump_redirect_unit_pkg::*;
#(
  parameter int NUM_SRC   = JR_NUM_SRC_DEF,
  parameter int SRC_IDX_W = JR_SRC_IDX_W_DEF
) (
  input  logic [NUM_SRC-1:0]   src_valid,
  output logic [SRC_IDX_W-1:0] win,
  output logic                 any
);

  // Walk from the lowest priority upward so the lowest set index wins.
  always_comb begin
    win = {SRC_IDX_W{1'b0}};
    any = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      win = src_valid[i] ? SRC_IDX_W'(i) : win;
      any = any | src_valid[i];
    end
  end

endmodule

// File: rtl/jump_redirect_unit.sv
// Registers the highest-priority jump target and holds it as a valid/ready
// redirect until fetch accepts it. Define JUMP_REDIRECT_STATS_EN for redir_count.
module jump_redirect_unit
  import jump_redirect_unit_pkg::*;
#(
  parameter int ADDR_W    = JR_PC_W,
  parameter int NUM_SRC   = JR_NUM_SRC_DEF,
  parameter int SRC_IDX_W = JR_SRC_IDX_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
  input  logic                      flush,
  input  logic                      redir_ready,
  output logic                      redir_valid,
  output logic [ADDR_W-1:0]         redir_addr,
  output logic [SRC_IDX_W-1:0]      redir_src,
  output logic                      busy,
  output logic [15:0]               redir_count
);

  jr_state_t             state;
  jr_state_t             state_nxt;
  logic [SRC_IDX_W-1:0]  win;
  logic                  any;
  logic                  load;
  logic [ADDR_W-1:0]     sel_addr;

  jump_src_prio_enc #(
    .NUM_SRC   (NUM_SRC),
    .SRC_IDX_W (SRC_IDX_W)
  ) u_prio_enc (
    .src_valid (src_valid),
    .win       (win),
    .any       (any)
  );

  // Pick the winning source's target out of the packed bus.
  always_comb begin
    sel_addr = {ADDR_W{1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      sel_addr = (win == SRC_IDX_W'(i)) ? src_addr[i*ADDR_W +: ADDR_W] : sel_addr;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= JR_STATE_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and capture enable; flush overrides everything.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      JR_STATE_IDLE: begin
        if (flush) begin
          state_nxt = JR_STATE_IDLE;
        end else if (any) begin
          state_nxt = JR_STATE_PEND;
          load      = 1'b1;
        end else begin
          state_nxt = JR_STATE_IDLE;
        end
      end
      JR_STATE_PEND: begin
        if (flush) begin
          state_nxt = JR_STATE_IDLE;
        end else if (redir_ready) begin
          state_nxt = any ? JR_STATE_PEND : JR_STATE_IDLE;
          load      = any;
        end else begin
          // Stalled: only a strictly higher-priority request may replace the target.
          state_nxt = JR_STATE_PEND;
          load      = any & jr_outranks(8'(win), 8'(redir_src));
        end
      end
      default: begin
        state_nxt = JR_STATE_IDLE;
        load      = 1'b0;
      end
    endcase
  end

  // Redirect target and source registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redir_addr <= {ADDR_W{1'b0}};
      redir_src  <= {SRC_IDX_W{1'b0}};
    end else if (load) begin
      redir_addr <= sel_addr;
      redir_src  <= win;
    end else begin
      redir_addr <= redir_addr;
      redir_src  <= redir_src;
    end
  end

  // Valid and busy come straight from the state flop.
  always_comb begin
    redir_valid = (state == JR_STATE_PEND);
    busy        = (state == JR_STATE_PEND);
  end

`ifdef JUMP_REDIRECT_STATS_EN
  logic [15:0] count;

  // Saturating count of accepted redirects; a flushed handshake is not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 16'h0000;
    end else if (redir_valid && redir_ready && !flush && (count != 16'hFFFF)) begin
      count <= count + 16'h0001;
    end else begin
      count <= count;
    end
  end

  assign redir_count = count;
`else
  assign redir_count = 16'h0000;
`endif

endmodule

// File: tb/tb_jump_redirect_unit.sv
// Self-checking bench for jump_redirect_unit: table of per-cycle vectors plus
// hand sequences for reset-while-pending and counter behaviour.
module tb_jump_redirect_unit;

  logic        clk;
  logic        rst;
  logic [2:0]  src_valid;
  logic [47:0] src_addr;
  logic        flush;
  logic        redir_ready;
  logic        redir_valid;
  logic [15:0] redir_addr;
  logic [2:0]  redir_src;
  logic        busy;
  logic [15:0] redir_count;

  jump_redirect_unit #(
    .ADDR_W    (16),
    .NUM_SRC   (3),
    .SRC_IDX_W (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .src_valid   (src_valid),
    .src_addr    (src_addr),
    .flush       (flush),
    .redir_ready (redir_ready),
    .redir_valid (redir_valid),
    .redir_addr  (redir_addr),
    .redir_src   (redir_src),
    .busy        (busy),
    .redir_count (redir_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  v;
    logic [15:0] a0;
    logic [15:0] a1;
    logic [15:0] a2;
    logic        fl;
    logic        rdy;
    logic        ev;
    logic [15:0] ea;
    logic [2:0]  es;
  } vec_t;

  typedef struct packed {
    logic        ev;
    logic [15:0] ea;
    logic [2:0]  es;
    logic [15:0] ecnt;
  } exp_t;

  exp_t  sb[$];
  vec_t  tbl[20];
  int    n_vec  = 0;
  int    n_fail = 0;
  logic  model_valid = 1'b0;
  logic [15:0] model_cnt = 16'h0000;

  function automatic logic [15:0] cnt_expect(input logic [15:0] c);
`ifdef JUMP_REDIRECT_STATS_EN
    return c;
`else
    return 16'h0000;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, push its expected result, then compare after the edge.
  task automatic step(input vec_t t);
    exp_t e;
    exp_t got;
    @(negedge clk);
    src_valid   = t.v;
    src_addr    = {t.a2, t.a1, t.a0};
    flush       = t.fl;
    redir_ready = t.rdy;
    if (model_valid && t.rdy && !t.fl && model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'h0001;
    model_valid = t.ev;
    e.ev   = t.ev;
    e.ea   = t.ea;
    e.es   = t.es;
    e.ecnt = cnt_expect(model_cnt);
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check("redir_valid", {31'd0, redir_valid}, {31'd0, got.ev});
    check("busy", {31'd0, busy}, {31'd0, got.ev});
    if (got.ev) begin
      check("redir_addr", {16'd0, redir_addr}, {16'd0, got.ea});
      check("redir_src", {29'd0, redir_src}, {29'd0, got.es});
    end
    check("redir_count", {16'd0, redir_count}, {16'd0, got.ecnt});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_valid", {31'd0, redir_valid}, 32'd0);
    check("rst_addr", {16'd0, redir_addr}, 32'd0);
    check("rst_src", {29'd0, redir_src}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_count", {16'd0, redir_count}, 32'd0);
    src_valid   = 3'b000;
    flush       = 1'b0;
    redir_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_valid = 1'b0;
    model_cnt   = 16'h0000;
  endtask

  initial begin
    rst         = 1'b1;
    src_valid   = 3'b000;
    src_addr    = 48'h0;
    flush       = 1'b0;
    redir_ready = 1'b0;

    //            v       a0        a1        a2        fl    rdy   ev    ea        es
    tbl[0]  = '{3'b010, 16'h0000, 16'h00A0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h00A0, 3'd1};
    tbl[1]  = '{3'b000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd0};
    tbl[2]  = '{3'b110, 16'h0000, 16'h0100, 16'h0200, 1'b0, 1'b0, 1'b1, 16'h0100, 3'd1};
    tbl[3]  = '{3'b000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd0};
    tbl[4]  = '{3'b100, 16'h0000, 16'h0000, 16'h0200, 1'b0, 1'b0, 1'b1, 16'h0200, 3'd2};
    tbl[5]  = '{3'b001, 16'h0040, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0040, 3'd0};
    tbl[6]  = '{3'b010, 16'h0000, 16'h0111, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0040, 3'd0};
    tbl[7]  = '{3'b001, 16'h0050, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0040, 3'd0};
    tbl[8]  = '{3'b010, 16'h0000, 16'h0300, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0300, 3'd1};
    tbl[9]  = '{3'b100, 16'h0000, 16'h0000, 16'h0222, 1'b0, 1'b1, 1'b1, 16'h0222, 3'd2};
    tbl[10] = '{3'b011, 16'h0400, 16'h0401, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0};
    tbl[11] = '{3'b001, 16'h0500, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0};
    tbl[12] = '{3'b100, 16'h0000, 16'h0000, 16'h0600, 1'b0, 1'b0, 1'b1, 16'h0600, 3'd2};
    tbl[13] = '{3'b000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0600, 3'd2};
    tbl[14] = '{3'b000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0};
    tbl[15] = '{3'b111, 16'h0700, 16'h0701, 16'h0702, 1'b0, 1'b0, 1'b1, 16'h0700, 3'd0};
    tbl[16] = '{3'b000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd0};
    tbl[17] = '{3'b001, 16'hFFFE, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hFFFE, 3'd0};
    tbl[18] = '{3'b001, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1, 16'hFFFF, 3'd0};
    tbl[19] = '{3'b000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0};

    // Reset state before any edge.
    #2;
    check("init_valid", {31'd0, redir_valid}, 32'd0);
    check("init_count", {16'd0, redir_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      step(tbl[i]);
    end

    // Reset while a redirect is pending discards it without counting.
    step('{3'b001, 16'h1234, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h1234, 3'd0});
    do_reset();
    step('{3'b000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd0});

    // Five accepted handshakes back to back, then one handshake under flush.
    for (int k = 0; k < 5; k++) begin
      step('{3'b010, 16'h0000, 16'(16'h0A00 + k), 16'h0000, 1'b0, 1'b1, 1'b1, 16'(16'h0A00 + k), 3'd1});
    end
    step('{3'b000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd0});
    step('{3'b100, 16'h0000, 16'h0000, 16'h0B00, 1'b0, 1'b0, 1'b1, 16'h0B00, 3'd2});
    step('{3'b000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0});
`ifdef JUMP_REDIRECT_STATS_EN
    check("stats_total", {16'd0, redir_count}, 32'd5);
`else
    check("stats_total", {16'd0, redir_count}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/jump_redirect_unit.md
Name: jump_redirect_unit

Overview:
- Parametrised successor to the jump-address selector.
- Arbitrates NUM_SRC jump-target sources (ALU result, jump-adder answer, exception vector, ...) by fixed priority.
- Registers the winning target and holds it as a valid/ready redirect to the fetch stage until it is accepted, so a stalled fetch never loses a jump.
- Sits between EX/ID jump logic and the PC register.

Parameters:
- ADDR_W, 16: PC / jump-address width in bits.
- NUM_SRC, 3: number of jump-target sources. Index 0 has the highest priority. Legal range 1..8.
- SRC_IDX_W, 3: width of the source-index field. Must satisfy 2^SRC_IDX_W >= NUM_SRC.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- src_valid  in  NUM_SRC  per-source request strobe.
- src_addr  in  NUM_SRC*ADDR_W  packed targets; source i occupies bits [i*ADDR_W +: ADDR_W].
- flush  in  1  drop any pending or incoming redirect (exception/squash).
- redir_ready  in  1  fetch stage accepts redirect this cycle.
- redir_valid  out  1  registered redirect pending.
- redir_addr  out  ADDR_W  registered target.
- redir_src  out  SRC_IDX_W  index of the source that produced redir_addr.
- busy  out  1  equals redir_valid; provided for hazard/stall logic.
- redir_count  out  16  accepted-redirect counter (optional feature).

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - redir_valid=0, redir_addr=0, redir_src=0, redir_count=0.
  - Holds while rst is high. Reset mid-PEND discards the held redirect with no acceptance counted.
- Selection (combinational): win = lowest index i with src_valid[i]=1. any = OR of src_valid.
- States: IDLE and PEND. redir_valid=1 exactly in PEND.
- IDLE:
  - flush=1: stay IDLE.
  - any=1: capture src_addr[win] and win; go to PEND.
  - Latency is 1 cycle: request in cycle N gives redir_valid=1 in N+1.
- PEND with redir_ready=1 (handshake complete this cycle):
  - flush=1 → IDLE.
  - else any=1 → capture the new winner and stay PEND (back-to-back, no bubble).
  - else → IDLE.
- PEND with redir_ready=0:
  - flush=1 → IDLE.
  - else any=1 and win < redir_src → replace addr/src with the higher-priority request and stay PEND.
  - else hold; lower- or equal-priority requests are dropped.
- flush has top priority over every simultaneous event.
- redir_addr and redir_src are stable while redir_valid=1 and redir_ready=0, except for a strictly-higher-priority replacement.
- redir_ready is ignored in IDLE.
- No width conversion: addresses pass through unmodified. No X on any output after reset.

Optional Feature:
- Macro: JUMP_REDIRECT_STATS_EN.
- Defined:
  - redir_count increments by 1 on each cycle with redir_valid & redir_ready & ~flush.
  - Saturates at 16'hFFFF.
  - Async-cleared by rst.
- Undefined: redir_count is driven constant 0 and no counter flops exist.

Decomposition:
- Shared defines file (extend the existing one):
  - PC bus width.
  - Redirect state encodings JR_STATE_IDLE=1'b0 and JR_STATE_PEND=1'b1.
  - Default NUM_SRC.
  - Source-index constants JR_SRC_ALU=0, JR_SRC_JANS=1, JR_SRC_EXC=2.
- One natural sub-module: jump_src_prio_enc, a parametrised combinational priority encoder (src_valid → win, any).
- Top holds the FSM, registers and counter.

Test Plan:
- Reset: assert rst mid-PEND (addr 16'h1234 held) → outputs 0 immediately, before any clock edge; after release, state=IDLE.
- Single request, ready=1: src_valid=3'b010, src1=16'h00A0 → next cycle redir_valid=1, addr=16'h00A0, src=1; after acceptance returns to IDLE with valid=0.
- Simultaneous sources: src_valid=3'b110, src1=16'h0100, src2=16'h0200 → addr=16'h0100, src=1.
- Stall and replace: held src=2 addr=16'h0200, ready=0, then src0=16'h0040 arrives → addr=16'h0040, src=0. A subsequent src1 request while still stalled is ignored.
- Back-to-back: PEND with ready=1 and new src1=16'h0300 in the same cycle → valid stays 1 with no gap, addr=16'h0300. Flush asserted with src_valid and ready=1 → IDLE, valid=0.
- Stats (macro defined): 5 accepted handshakes plus 1 handshake under flush → redir_count=5. Without the macro, redir_count is always 0.
